// File: rtl/alu_operand_loader.sv
// Operand sequencer in front of the ALU: synchronises switches and buttons,
// debounces the load button and captures A, B and the operation select in turn.
module alu_operand_loader #(
  parameter int N          = 4,
  parameter int OPW        = 4,
  parameter int DEB_CYCLES = 500000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   sw,
  input  logic           btn_load,
  input  logic           btn_clear,
  output logic [N-1:0]   A_num,
  output logic [N-1:0]   B_num,
  output logic [OPW-1:0] op_sel,
  output logic           valid,
  output logic [1:0]     state_code
);

  localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  typedef enum logic [1:0] {
    LOAD_A  = 2'b00,
    LOAD_B  = 2'b01,
    LOAD_OP = 2'b10,
    READY   = 2'b11
  } state_t;

  state_t state, state_nx;

  logic [N-1:0]   sw_p0, sw_p1;
  logic           ld_p0, ld_p1;
  logic           clr_p0, clr_p1;
  logic [CNT_W-1:0] deb_cnt;
  logic           deb_level, deb_prev;
  logic           load_evt;
  logic           ld_a, ld_b, ld_op;

  // Stage p0/p1: two-flop synchronisers for every asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_p0  <= '0;
      sw_p1  <= '0;
      ld_p0  <= 1'b0;
      ld_p1  <= 1'b0;
      clr_p0 <= 1'b0;
      clr_p1 <= 1'b0;
    end else begin
      sw_p0  <= sw;
      sw_p1  <= sw_p0;
      ld_p0  <= btn_load;
      ld_p1  <= ld_p0;
      clr_p0 <= btn_clear;
      clr_p1 <= clr_p0;
    end
  end

  // Debounce stage: level accepted only after DEB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt   <= '0;
      deb_level <= 1'b0;
      deb_prev  <= 1'b0;
    end else begin
      deb_prev <= deb_level;
      if (ld_p1 != deb_level) begin
        if (deb_cnt == CNT_W'(DEB_CYCLES - 1)) begin
          deb_level <= ld_p1;
          deb_cnt   <= '0;
        end else begin
          deb_cnt <= deb_cnt + CNT_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign load_evt = deb_level & ~deb_prev;

  // Capture stage: sequencing FSM, clear takes priority over a same-cycle press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD_A;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    ld_op    = 1'b0;
    if (clr_p1) begin
      state_nx = LOAD_A;
    end else if (load_evt) begin
      case (state)
        LOAD_A: begin
          ld_a     = 1'b1;
          state_nx = LOAD_B;
        end
        LOAD_B: begin
          ld_b     = 1'b1;
          state_nx = LOAD_OP;
        end
        LOAD_OP: begin
          ld_op    = 1'b1;
          state_nx = READY;
        end
        default: begin
          ld_a     = 1'b1;
          state_nx = LOAD_B;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A_num  <= '0;
      B_num  <= '0;
      op_sel <= '0;
      valid  <= 1'b0;
    end else if (clr_p1) begin
      A_num  <= '0;
      B_num  <= '0;
      op_sel <= '0;
      valid  <= 1'b0;
    end else begin
      if (ld_a) A_num  <= sw_p1;
      if (ld_b) B_num  <= sw_p1;
      if (ld_op) op_sel <= sw_p1[OPW-1:0];
      // Restarting from READY drops valid while B and op keep their old values
      if (ld_op)     valid <= 1'b1;
      else if (ld_a) valid <= 1'b0;
    end
  end

  assign state_code = state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader: a sequence-level model is compared every
// cycle, and hand-computed expectations pin key points of each scenario.
module tb_alu_operand_loader;

  localparam int N   = 4;
  localparam int OPW = 4;
  localparam int DEB = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   sw;
  logic           btn_load;
  logic           btn_clear;
  logic [N-1:0]   A_num;
  logic [N-1:0]   B_num;
  logic [OPW-1:0] op_sel;
  logic           valid;
  logic [1:0]     state_code;

  int checks = 0;
  int errors = 0;

  alu_operand_loader #(.N(N), .OPW(OPW), .DEB_CYCLES(DEB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw         (sw),
    .btn_load   (btn_load),
    .btn_clear  (btn_clear),
    .A_num      (A_num),
    .B_num      (B_num),
    .op_sel     (op_sel),
    .valid      (valid),
    .state_code (state_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: inputs seen two edges late; the debounced level flips once the
  // last DEB synchronised samples all disagree with it; a step index 0..3
  // walks through the capture sequence.
  logic [N-1:0] m_sw1, m_sw2;
  bit           m_ld1, m_ld2, m_cl1, m_cl2;
  bit           m_deb, m_prev, m_evt, m_all;
  bit           m_hist [DEB];
  int           m_step;
  logic [N-1:0] m_a, m_b, m_op;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sw1 = '0; m_sw2 = '0;
      m_ld1 = 0;  m_ld2 = 0; m_cl1 = 0; m_cl2 = 0;
      m_deb = 0;  m_prev = 0;
      for (int i = 0; i < DEB; i++) m_hist[i] = 0;
      m_step = 0; m_a = '0; m_b = '0; m_op = '0;
    end else begin
      m_evt = m_deb && !m_prev;
      if (m_cl2) begin
        m_step = 0; m_a = '0; m_b = '0; m_op = '0;
      end else if (m_evt) begin
        case (m_step)
          0: begin m_a  = m_sw2; m_step = 1; end
          1: begin m_b  = m_sw2; m_step = 2; end
          2: begin m_op = m_sw2; m_step = 3; end
          default: begin m_a = m_sw2; m_step = 1; end
        endcase
      end
      m_prev = m_deb;
      for (int i = DEB - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = m_ld2;
      m_all = 1;
      for (int i = 0; i < DEB; i++) if (m_hist[i] == m_deb) m_all = 0;
      if (m_all) m_deb = !m_deb;
      m_sw2 = m_sw1; m_sw1 = sw;
      m_ld2 = m_ld1; m_ld1 = btn_load;
      m_cl2 = m_cl1; m_cl1 = btn_clear;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("model_A",     32'(A_num),      32'(m_a));
    chk("model_B",     32'(B_num),      32'(m_b));
    chk("model_op",    32'(op_sel),     32'(m_op));
    chk("model_valid", 32'(valid),      32'(m_step == 3));
    chk("model_state", 32'(state_code), 32'(m_step));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [N-1:0] v, input int hold);
    sw       = v;
    btn_load = 1'b1;
    tick(hold);
    btn_load = 1'b0;
    tick(10);
  endtask

  task automatic expect_all(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic [OPW-1:0] op, input logic v, input logic [1:0] st);
    chk({tag, "_A"},     32'(A_num),      32'(a));
    chk({tag, "_B"},     32'(B_num),      32'(b));
    chk({tag, "_op"},    32'(op_sel),     32'(op));
    chk({tag, "_valid"}, 32'(valid),      32'(v));
    chk({tag, "_state"}, 32'(state_code), 32'(st));
  endtask

  initial begin
    rst_n     = 1'b0;
    sw        = 4'hF;
    btn_load  = 1'b1;
    btn_clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      expect_all("reset_hold", 4'h0, 4'h0, 4'h0, 1'b0, 2'b00);
    end
    btn_load = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(3);

    // First capture latency: visible after edge 7, not after edge 6
    sw       = 4'h5;
    btn_load = 1'b1;
    tick(6);
    chk("lat_edge6_A", 32'(A_num), 32'h0);
    tick(1);
    chk("lat_edge7_A", 32'(A_num), 32'h5);
    chk("lat_edge7_state", 32'(state_code), 32'h1);
    tick(3);
    btn_load = 1'b0;
    tick(10);
    press(4'h3, 10);
    expect_all("after_B", 4'h5, 4'h3, 4'h0, 1'b0, 2'b01 + 2'b01);
    press(4'h2, 10);
    expect_all("full_seq", 4'h5, 4'h3, 4'h2, 1'b1, 2'b11);

    press(4'h9, 10);
    expect_all("restart", 4'h9, 4'h3, 4'h2, 1'b0, 2'b01);

    // Bouncing press never stays high DEB cycles in a row
    sw = 4'hE;
    btn_load = 1'b1; tick(3);
    btn_load = 1'b0; tick(1);
    btn_load = 1'b1; tick(2);
    btn_load = 1'b0; tick(12);
    expect_all("bounce", 4'h9, 4'h3, 4'h2, 1'b0, 2'b01);
    press(4'h6, 6);
    expect_all("clean6", 4'h9, 4'h6, 4'h2, 1'b0, 2'b10);

    // Clear synchronised into the same cycle the load event fires
    sw       = 4'hA;
    btn_load = 1'b1;
    tick(4);
    btn_clear = 1'b1;
    tick(3);
    expect_all("clear_prio", 4'h0, 4'h0, 4'h0, 1'b0, 2'b00);
    tick(4);
    expect_all("clear_held", 4'h0, 4'h0, 4'h0, 1'b0, 2'b00);
    btn_clear = 1'b0;
    btn_load  = 1'b0;
    tick(10);

    press(4'h7, 10);
    expect_all("pre_rst", 4'h7, 4'h0, 4'h0, 1'b0, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    expect_all("async_rst", 4'h0, 4'h0, 4'h0, 1'b0, 2'b00);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    press(4'hC, 10);
    expect_all("post_rst", 4'hC, 4'h0, 4'h0, 1'b0, 2'b01);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
- Upstream input stage for the N-bit ALU and its per-operation units (XOR, AND, adders, and so on).
- Takes the board switch bus and a load push-button, and sequences three captures: operand A, then operand B, then the operation select.
- Presents A_num, B_num and op_sel as stable registered values, plus a valid flag, to the combinational ALU datapath.
- Includes button synchronisation and debounce, so the ALU never sees metastable or bouncing inputs.

Parameters:
- N, 4, operand width; matches the ALU's N.
- OPW, 4, operation-select width; must satisfy OPW <= N.
- DEB_CYCLES, 500000, number of consecutive stable clock cycles needed to accept a load-button level change; must be >= 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sw  input  N  raw switch bus, asynchronous to clk.
- btn_load  input  1  raw load push-button, active-high, bouncing.
- btn_clear  input  1  raw clear push-button, active-high.
- A_num  output  N  registered operand A.
- B_num  output  N  registered operand B.
- op_sel  output  OPW  registered operation select.
- valid  output  1  high when A_num, B_num and op_sel form a complete set.
- state_code  output  2  current state, for LEDs: 00 LOAD_A, 01 LOAD_B, 10 LOAD_OP, 11 READY.

Behaviour:
- Reset:
  - Asynchronous, active-low: clock and reset are a single clk with rst_n asynchronous active-low; this is fixed.
  - On rst_n low: A_num=0, B_num=0, op_sel=0, valid=0, state=LOAD_A (state_code=00).
  - All synchroniser flops, debounce counter and debounced level are cleared to 0.
  - Reset asserted mid-sequence discards any partial capture. Release is taken synchronously on the next clk edge.
- Synchronisers:
  - btn_load and btn_clear each pass through a 2-flop synchroniser.
  - sw passes through a 2-flop synchroniser (sw_s) and is sampled only from sw_s.
- Debounce (load only):
  - While the synchronised load level differs from deb_level, the counter increments each cycle.
  - If the levels agree, the counter resets to 0.
  - When the counter equals DEB_CYCLES-1 and the levels still differ, deb_level takes the new value and the counter returns to 0.
  - A glitch shorter than DEB_CYCLES synchronised cycles produces no change.
- Load event:
  - load_evt = deb_level & ~deb_prev, where deb_prev is deb_level delayed one cycle.
  - load_evt is exactly one cycle per accepted press; release produces no event.
- Timing: with btn_load and sw stable from before edge 1, deb_level rises at edge 2+DEB_CYCLES, and the capture is visible after edge 3+DEB_CYCLES.
- FSM (on load_evt):
  - LOAD_A: A_num<=sw_s, go to LOAD_B.
  - LOAD_B: B_num<=sw_s, go to LOAD_OP.
  - LOAD_OP: op_sel<=sw_s[OPW-1:0], valid<=1, go to READY.
  - READY: A_num<=sw_s, valid<=0, go to LOAD_B. B_num and op_sel hold their old values until overwritten.
  - With no load_evt, all registers hold.
- Clear:
  - A synchronised btn_clear high, level-sensitive and checked every cycle, forces A_num=B_num=op_sel=0, valid=0, state=LOAD_A on the next edge.
  - Clear has priority over a same-cycle load_evt; that event is dropped.
  - Clear does not reset the debounce logic.
  - A held clear keeps the block in LOAD_A with zeroed outputs.
- Outputs change only on clk edges and are glitch-free.
- valid is high only in READY.

Test Plan (bench uses DEB_CYCLES=4, N=4, OPW=4):
- Reset: rst_n=0 with sw=4'hF, btn_load=1 → all outputs 0, state_code=00; outputs stay 0 while reset is held.
- Full sequence: sw=4'h5 and press load for 10 cycles; sw=4'h3 and press; sw=4'h2 and press → A_num=5, B_num=3, op_sel=2, valid=1, state_code=11. The first capture is visible exactly 7 edges after the button rises.
- Bounce: btn_load pulses high for 3 cycles, low 1, high 2, low 1 → no state change; a subsequent clean 6-cycle hold → exactly one capture.
- Restart from READY: in READY with A=5, B=3, op=2, set sw=4'h9 and press → A_num=9, valid=0, state_code=01, B_num still 3.
- Clear priority: in LOAD_OP, assert btn_clear in the same cycle that load_evt fires → state_code=00, all outputs 0, op_sel not loaded.
- Async reset mid-sequence: drop rst_n between edges while in LOAD_B with A=7 → outputs go to 0 immediately, without waiting for a clk edge; after release, the next press loads A.
